// File: rtl/conv_scan.sv
// Purpose: latches an image tile and kernel on start, then walks every output window emitting one (pixel, weight) pair per clock.
// Latency: pair n is registered at edge T+1+n after start at edge T; one FLUSH cycle with srh_fin follows the last pair.
// Backpressure: none; the scan free-runs once started, and start is ignored while busy.
module conv_scan #(
    parameter int weight_width  = 2,
    parameter int weight_height = 2,
    parameter int img_width     = 4,
    parameter int img_height    = 4,
    parameter int padding       = 0,
    parameter int stride        = 1,
    parameter int bitwidth      = 3
) (
    input  logic                                          clk_en,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic [img_width*img_height*bitwidth-1:0]      img,
    input  logic [weight_width*weight_height*bitwidth-1:0] wei,
    output logic                                          busy,
    output logic                                          conv_on,
    output logic [bitwidth-1:0]                           img_cal,
    output logic [bitwidth-1:0]                           wei_cal,
    output logic [3:0]                                    rlt_l,
    output logic [3:0]                                    rlt_c,
    output logic                                          chge_rlt,
    output logic                                          chge_rlt_q,
    output logic                                          srh_fin
);

    localparam int result_width  = (img_width  - weight_width  + 2*padding) / stride + 1;
    localparam int result_height = (img_height - weight_height + 2*padding) / stride + 1;
    localparam int IMG_N  = img_width * img_height;
    localparam int WEI_N  = weight_width * weight_height;
    localparam int KC_W   = (weight_width  > 1) ? $clog2(weight_width)  : 1;
    localparam int KL_W   = (weight_height > 1) ? $clog2(weight_height) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH} state_t;

    state_t                                   r_state;
    state_t                                   w_next;
    logic [IMG_N*bitwidth-1:0]                r_img;
    logic [WEI_N*bitwidth-1:0]                r_wei;
    logic [KC_W-1:0]                          r_kc;
    logic [KL_W-1:0]                          r_kl;
    logic [3:0]                               r_rc;
    logic [3:0]                               r_rl;
    logic [3:0]                               r_out_rl;
    logic [3:0]                               r_out_rc;
    logic                                     r_busy;
    logic                                     r_conv_on;
    logic [bitwidth-1:0]                      r_img_cal;
    logic [bitwidth-1:0]                      r_wei_cal;
    logic [3:0]                               r_rlt_l;
    logic [3:0]                               r_rlt_c;
    logic                                     r_chge;
    logic                                     r_chge_q;
    logic                                     r_fin;

    logic                                     w_last_kc;
    logic                                     w_last_kl;
    logic                                     w_last_rc;
    logic                                     w_last_rl;
    logic                                     w_last;
    int                                       w_sr;
    int                                       w_sc;
    int                                       w_pidx;
    int                                       w_kidx;
    logic                                     w_in;
    logic [bitwidth-1:0]                      w_pix;
    logic [bitwidth-1:0]                      w_wgt;

    assign w_last_kc = (r_kc == KC_W'(weight_width - 1));
    assign w_last_kl = (r_kl == KL_W'(weight_height - 1));
    assign w_last_rc = (r_rc == 4'(result_width - 1));
    assign w_last_rl = (r_rl == 4'(result_height - 1));
    assign w_last    = w_last_kc && w_last_kl && w_last_rc && w_last_rl;

    // Source pixel/weight selection; signed indices so the padded border falls out as out-of-range.
    always_comb begin
        w_sr   = int'(r_rl) * stride + int'(r_kl) - padding;
        w_sc   = int'(r_rc) * stride + int'(r_kc) - padding;
        w_in   = (w_sr >= 0) && (w_sr < img_height) && (w_sc >= 0) && (w_sc < img_width);
        w_pidx = w_sr * img_width + w_sc;
        w_kidx = int'(r_kl) * weight_width + int'(r_kc);
        w_pix  = '0;
        w_wgt  = '0;
        for (int i = 0; i < IMG_N; i++) begin
            if (w_in && (i == w_pidx)) w_pix = r_img[i*bitwidth +: bitwidth];
        end
        for (int j = 0; j < WEI_N; j++) begin
            if (j == w_kidx) w_wgt = r_wei[j*bitwidth +: bitwidth];
        end
    end

    // Next-state: IDLE -> SCAN on start, SCAN -> FLUSH after the last pair, FLUSH lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_SCAN;
            S_SCAN:  if (w_last) w_next = S_FLUSH;
            S_FLUSH:             w_next = S_IDLE;
            default:             w_next = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_en) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Counters, latched operands and registered outputs for the current state.
    always_ff @(posedge clk_en) begin
        if (!rst_n) begin
            r_img     <= '0;
            r_wei     <= '0;
            r_kc      <= '0;
            r_kl      <= '0;
            r_rc      <= '0;
            r_rl      <= '0;
            r_out_rl  <= '0;
            r_out_rc  <= '0;
            r_busy    <= 1'b0;
            r_conv_on <= 1'b0;
            r_img_cal <= '0;
            r_wei_cal <= '0;
            r_rlt_l   <= '0;
            r_rlt_c   <= '0;
            r_chge    <= 1'b0;
            r_chge_q  <= 1'b0;
            r_fin     <= 1'b0;
        end else begin
            r_chge_q <= r_chge;
            // Result coordinates trail the shown pair by one cycle to line up with the MAC.
            r_rlt_l  <= r_out_rl;
            r_rlt_c  <= r_out_rc;
            case (r_state)
                S_SCAN: begin
                    r_busy    <= 1'b1;
                    r_conv_on <= 1'b1;
                    r_img_cal <= w_pix;
                    r_wei_cal <= w_wgt;
                    r_chge    <= (r_kc == '0) && (r_kl == '0) && ((r_rl != '0) || (r_rc != '0));
                    r_fin     <= 1'b0;
                    r_out_rl  <= r_rl;
                    r_out_rc  <= r_rc;
                    if (!w_last_kc) begin
                        r_kc <= r_kc + KC_W'(1);
                    end else begin
                        r_kc <= '0;
                        if (!w_last_kl) begin
                            r_kl <= r_kl + KL_W'(1);
                        end else begin
                            r_kl <= '0;
                            if (!w_last_rc) begin
                                r_rc <= r_rc + 4'd1;
                            end else begin
                                r_rc <= '0;
                                if (!w_last_rl) r_rl <= r_rl + 4'd1;
                                else            r_rl <= '0;
                            end
                        end
                    end
                end
                S_FLUSH: begin
                    r_busy    <= 1'b1;
                    r_conv_on <= 1'b1;
                    r_img_cal <= '0;
                    r_wei_cal <= '0;
                    r_chge    <= 1'b0;
                    r_fin     <= 1'b1;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_conv_on <= 1'b0;
                    r_img_cal <= '0;
                    r_wei_cal <= '0;
                    r_chge    <= 1'b0;
                    r_fin     <= 1'b0;
                    if (start) begin
                        r_img <= img;
                        r_wei <= wei;
                        r_kc  <= '0;
                        r_kl  <= '0;
                        r_rc  <= '0;
                        r_rl  <= '0;
                    end
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign conv_on    = r_conv_on;
    assign img_cal    = r_img_cal;
    assign wei_cal    = r_wei_cal;
    assign rlt_l      = r_rlt_l;
    assign rlt_c      = r_rlt_c;
    assign chge_rlt   = r_chge;
    assign chge_rlt_q = r_chge_q;
    assign srh_fin    = r_fin;

endmodule

// File: doc/conv_scan.md
Name: conv_scan

Overview:
- Upstream sequencer for the convolution result/MAC stage.
- Latches one flattened image tile and one flattened kernel on start.
- Walks every output window in raster order. For each window it walks every kernel element, emitting one (pixel, weight) pair per clock.
- Drives the result coordinates, the window-change strobes and the finish strobe used by the accumulate-and-store stage.

Parameters:
- weight_width, 2, kernel columns
- weight_height, 2, kernel rows
- img_width, 4, image columns
- img_height, 4, image rows
- padding, 0, zero border width on each side (0 = none)
- stride, 1, window step in both directions
- bitwidth, 3, pixel/weight width, unsigned
- result_width, (img_width-weight_width+2*padding)/stride+1, derived; must be ≤16
- result_height, (img_height-weight_height+2*padding)/stride+1, derived; must be ≤16

Ports:
- clk_en  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin a scan; sampled only when busy=0
- img  in  img_width*img_height*bitwidth  pixel (r,c) at bits [(r*img_width+c)*bitwidth +: bitwidth]
- wei  in  weight_width*weight_height*bitwidth  weight (kl,kc) at [(kl*weight_width+kc)*bitwidth +: bitwidth]
- busy  out  1  scan in progress
- conv_on  out  1  MAC enable; pair valid
- img_cal  out  bitwidth  current pixel operand
- wei_cal  out  bitwidth  current weight operand
- rlt_l  out  4  result row of the window being stored
- rlt_c  out  4  result column of the window being stored
- chge_rlt  out  1  first pair of a new window (not the first window)
- chge_rlt_q  out  1  chge_rlt delayed one clock
- srh_fin  out  1  one-cycle end-of-scan strobe

Behaviour:
- Reset values:
  - rst_n=0 at a clock edge forces state IDLE and zeroes all counters and latched data.
  - Every output resets to 0.
  - Reset mid-scan aborts immediately; no srh_fin is issued.
- State machine: IDLE -> SCAN -> FLUSH -> IDLE.
- IDLE:
  - On start=1 at edge T, latch img and wei into internal registers.
  - Later changes on img/wei have no effect until the next accepted start.
  - Clear counters rl, rc, kl, kc and go to SCAN.
- SCAN:
  - Counter order, kc innermost: kc 0..weight_width-1, then kl 0..weight_height-1, then rc 0..result_width-1, then rl 0..result_height-1.
  - K = weight_width*weight_height. Total pairs N = result_width*result_height*K.
- Outputs are registered:
  - Pair n (n = 0..N-1) appears after edge T+1+n with conv_on=1.
  - Source row = rl*stride+kl-padding; source column = rc*stride+kc-padding. Use wide signed arithmetic (no wrap).
  - img_cal = latched pixel, or 0 if row/column is outside the image.
  - wei_cal = latched weight (kl,kc).
- Window strobes:
  - chge_rlt=1 exactly on the first pair (kl=kc=0) of every window except window (0,0).
  - chge_rlt_q mirrors chge_rlt one cycle later, including into FLUSH.
- Result coordinates:
  - rlt_l/rlt_c equal the (rl,rc) of the pair shown on the previous cycle, matching one-cycle MAC latency.
  - They hold the last window's (rl,rc) through FLUSH.
- FLUSH:
  - Lasts one cycle, at edge T+N+1: srh_fin=1, conv_on=1, img_cal=wei_cal=0, busy=1.
  - At edge T+N+2 return to IDLE: conv_on=0, srh_fin=0, busy=0. rlt_l/rlt_c keep their values.
- busy=1 from edge T+1 through T+N+1.
- start while busy=1 is ignored and not queued. start at T+N+2 is accepted normally.
- Weights and pixels are unsigned. No arithmetic is performed beyond index generation.

Test Plan:
- Default params; pixel(r,c)=(4r+c) mod 8; wei={1,2,3,4}; start at T:
  - T+1..T+4: img_cal 0,1,4,5 and wei_cal 1,2,3,4, conv_on=1.
  - chge_rlt=0 throughout window 0.
  - T+5: chge_rlt=1, img_cal=1. T+6: chge_rlt_q=1, rlt_c=1.
- Default scan length:
  - Exactly 8 chge_rlt pulses and 36 conv_on pair cycles.
  - srh_fin=1 only at T+37; busy=0 and conv_on=0 at T+38.
  - Final rlt_l=2, rlt_c=2.
- padding=1 (5x5 results, N=100):
  - First window pairs img_cal 0,0,0,pixel(0,0).
  - Last window (4,4) pairs pixel(3,3),0,0,0. srh_fin at T+101.
- stride=2 (2x2 results, N=16):
  - Window (0,1) begins at T+5 with img_cal=pixel(0,2)=2.
  - Window (1,0) begins at T+9 with img_cal=pixel(2,0)=0.
- Protocol and reset:
  - start held high continuously: a second scan begins only at T+38.
  - img changed at T+2: outputs still use the tile latched at T.
  - rst_n=0 at T+10: all outputs 0 next cycle, no srh_fin.
  - A new start after reset restarts at pair 0.
